// File: rtl/usr_seq_param.sv
// Parametrised sequential universal shift register: one shift/rotate step per clock under a
// start/busy/done handshake. Define USR_PARITY_EN to add a registered parity output.
module usr_seq_param #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sl_ser,
   input  logic             sr_ser,
   output logic [WIDTH-1:0] data_out,
   output logic             ser_out,
   output logic             busy,
`ifdef USR_PARITY_EN
   output logic             parity,
`endif
   output logic             done
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] data_q, data_nxt, step_data;
   logic             ser_q, ser_nxt, step_ser;
   logic             busy_q, done_q;
   logic [SHW-1:0]   cnt_q;
   logic [2:0]       mode_q, op_mode;
   logic             accept, is_shift, do_step, do_load;

   assign accept  = (state_q == StIdle) && start;
   // While running, the latched mode drives the datapath; live mode is ignored.
   assign op_mode = accept ? mode : mode_q;

   always_comb begin
      step_data = data_q;
      step_ser  = ser_q;
      is_shift  = 1'b1;
      case (op_mode)
         3'b001: begin
            step_data = {sr_ser, data_q[WIDTH-1:1]};
            step_ser  = data_q[0];
         end
         3'b010: begin
            step_data = {data_q[WIDTH-2:0], sl_ser};
            step_ser  = data_q[WIDTH-1];
         end
         3'b100: begin
            step_data = {data_q[0], data_q[WIDTH-1:1]};
            step_ser  = data_q[0];
         end
         3'b101: begin
            step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            step_ser  = data_q[WIDTH-1];
         end
         3'b110: begin
            step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            step_ser  = data_q[0];
         end
         default: is_shift = 1'b0;
      endcase
   end

   assign do_load  = accept && (mode == 3'b011);
   assign do_step  = (state_q == StRun) || (accept && is_shift && (shamt != '0));
   assign data_nxt = do_load ? data_in : (do_step ? step_data : data_q);
   assign ser_nxt  = do_step ? step_ser : ser_q;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= StIdle;
         data_q  <= '0;
         ser_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= '0;
      end else begin
         data_q <= data_nxt;
         ser_q  <= ser_nxt;
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  mode_q <= mode;
                  // Step 1 happens on this edge; cnt_q holds the steps still to come.
                  if (is_shift && (shamt > SHW'(1))) begin
                     cnt_q   <= shamt - SHW'(1);
                     busy_q  <= 1'b1;
                     state_q <= StRun;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            StRun: begin
               cnt_q <= cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef USR_PARITY_EN
   logic parity_q;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= ^data_nxt;
      end
   end

   assign parity = parity_q;
`endif

   assign data_out = data_q;
   assign ser_out  = ser_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_usr_seq_param.sv
// Scoreboard bench for usr_seq_param (WIDTH=8): driver queues hand-computed results, a monitor
// pops and compares on every done pulse.
module tb_usr_seq_param;

   logic       clock, clear, start, sl_ser, sr_ser;
   logic [2:0] mode;
   logic [3:0] shamt;
   logic [7:0] data_in, data_out;
   logic       ser_out, busy, done;
`ifdef USR_PARITY_EN
   logic       parity;
`endif

   usr_seq_param #(.WIDTH(8), .SHW(4)) dut (
      .clock(clock),
      .clear(clear),
      .start(start),
      .mode(mode),
      .shamt(shamt),
      .data_in(data_in),
      .sl_ser(sl_ser),
      .sr_ser(sr_ser),
      .data_out(data_out),
      .ser_out(ser_out),
      .busy(busy),
`ifdef USR_PARITY_EN
      .parity(parity),
`endif
      .done(done)
   );

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       ser;
      int         busy_cycles;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_done = 0;
   int   busy_cnt = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s op%0d: got %0h expected %0h", nm, id, act, exp);
      end
   endtask

   // Monitor: compares each completion against the oldest queued expectation.
   always @(negedge clock) begin
      exp_t e;
      if (clear) begin
         if (busy) busy_cnt++;
         if (done) begin
            n_done++;
            chk("done_with_busy", 0, {31'd0, busy}, 32'd0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
               e = q.pop_front();
               chk("data_out", e.id, {24'd0, data_out}, {24'd0, e.data});
               chk("ser_out", e.id, {31'd0, ser_out}, {31'd0, e.ser});
               chk("busy_cycles", e.id, busy_cnt, e.busy_cycles);
`ifdef USR_PARITY_EN
               chk("parity", e.id, {31'd0, parity}, {31'd0, ^e.data});
`endif
            end
            busy_cnt = 0;
         end
      end else begin
         busy_cnt = 0;
      end
   end

   // Called at a negedge; returns at the negedge where done is seen, so the next call
   // asserts start while done is still high (back-to-back).
   task automatic issue(input int id, input logic [2:0] m, input logic [3:0] sh,
                        input logic [7:0] din, input logic sl, input logic sr,
                        input logic [7:0] xd, input logic xs, input int xb, input int poke);
      exp_t e;
      bit   got;
      e.id = id; e.data = xd; e.ser = xs; e.busy_cycles = xb;
      q.push_back(e);
      start = 1'b1; mode = m; shamt = sh; data_in = din; sl_ser = sl; sr_ser = sr;
      @(posedge clock);
      #1;
      start = 1'b0; mode = 3'b011; shamt = 4'hf; data_in = 8'h00;
      got = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (done) begin
            got = 1'b1;
            break;
         end
         if (i == poke) start = 1'b1;
         if (i == poke + 1) start = 1'b0;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout op%0d: got no done expected done within 40 cycles", id);
      end
   endtask

   initial begin
      int done_before;
      clear = 1'b0; start = 1'b0; mode = 3'b000; shamt = 4'd0;
      data_in = 8'h00; sl_ser = 1'b0; sr_ser = 1'b0;
      #12;
      chk("reset_data", 0, {24'd0, data_out}, 32'd0);
      chk("reset_ser", 0, {31'd0, ser_out}, 32'd0);
      chk("reset_busy", 0, {31'd0, busy}, 32'd0);
      chk("reset_done", 0, {31'd0, done}, 32'd0);
      @(negedge clock);
      clear = 1'b1;
      //    id mode    sh     din    sl    sr    data   ser   busy poke
      issue(1, 3'b011, 4'd0, 8'hAB, 1'b0, 1'b0, 8'hAB, 1'b0, 0, 0);
      issue(2, 3'b001, 4'd3, 8'h00, 1'b0, 1'b1, 8'hF5, 1'b0, 2, 0);
      issue(3, 3'b011, 4'd7, 8'hAB, 1'b0, 1'b0, 8'hAB, 1'b0, 0, 0);
      issue(4, 3'b101, 4'd4, 8'h00, 1'b0, 1'b0, 8'hBA, 1'b0, 3, 0);
      issue(5, 3'b100, 4'd8, 8'h00, 1'b0, 1'b0, 8'hBA, 1'b1, 7, 0);
      issue(6, 3'b011, 4'd0, 8'hAB, 1'b0, 1'b0, 8'hAB, 1'b1, 0, 0);
      issue(7, 3'b110, 4'd2, 8'h00, 1'b0, 1'b0, 8'hEA, 1'b1, 1, 0);
      issue(8, 3'b011, 4'd0, 8'hAB, 1'b0, 1'b0, 8'hAB, 1'b1, 0, 0);
      issue(9, 3'b010, 4'd2, 8'h00, 1'b0, 1'b0, 8'hAC, 1'b0, 1, 0);
      issue(10, 3'b011, 4'd0, 8'hAB, 1'b0, 1'b0, 8'hAB, 1'b0, 0, 0);
      issue(11, 3'b100, 4'd5, 8'h00, 1'b0, 1'b0, 8'h5D, 1'b0, 4, 1);
      issue(12, 3'b001, 4'd0, 8'h00, 1'b0, 1'b1, 8'h5D, 1'b0, 0, 0);
      issue(13, 3'b000, 4'd5, 8'h00, 1'b0, 1'b0, 8'h5D, 1'b0, 0, 0);
      issue(14, 3'b111, 4'd3, 8'h00, 1'b0, 1'b0, 8'h5D, 1'b0, 0, 0);
      issue(15, 3'b010, 4'd10, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 9, 0);
      issue(16, 3'b001, 4'd9, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8, 0);
      issue(17, 3'b011, 4'd0, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 0, 0);
      issue(18, 3'b110, 4'd15, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 14, 0);
      issue(19, 3'b011, 4'd0, 8'hAB, 1'b0, 1'b0, 8'hAB, 1'b1, 0, 0);
`ifdef USR_PARITY_EN
      chk("parity_ab", 19, {31'd0, parity}, 32'd1);
`endif
      // Abort a 6-step shift after two steps with an asynchronous clear between edges.
      start = 1'b1; mode = 3'b001; shamt = 4'd6; sr_ser = 1'b0;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(posedge clock);
      #3;
      clear = 1'b0;
      #1;
      chk("abort_data", 20, {24'd0, data_out}, 32'd0);
      chk("abort_ser", 20, {31'd0, ser_out}, 32'd0);
      chk("abort_busy", 20, {31'd0, busy}, 32'd0);
      chk("abort_done", 20, {31'd0, done}, 32'd0);
`ifdef USR_PARITY_EN
      chk("abort_parity", 20, {31'd0, parity}, 32'd0);
`endif
      @(negedge clock);
      clear = 1'b1;
      done_before = n_done;
      repeat (12) @(negedge clock);
      chk("no_done_after_abort", 20, n_done, done_before);
      chk("idle_after_abort", 20, {31'd0, busy}, 32'd0);
      chk("data_after_abort", 20, {24'd0, data_out}, 32'd0);
      chk("scoreboard_empty", 20, q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
